iterative_divider: RTL

Multi-cycle 32-bit integer divider for the CPU's execute stage, implementing MIPS DIV/DIVU. It is the counterpart to the carry-save multiplier datapath: the multiplier reduces partial products combinationally, while this block iterates one quotient bit per cycle. It uses radix-2 restoring division on magnitudes with sign correction. It produces LO (quotient) and HI (remainder) under a valid/ready handshake, and supports a pipeline-flush cancel.

---
 rtl/iterative_divider.sv | 111 +++++++++++
 1 files changed

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle on
// operand magnitudes, sign-corrected results, valid/ready handshake with flush.
module iterative_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_n;
  logic [WIDTH:0]     rem_q, rem_n, shifted, diff;
  logic [WIDTH-1:0]   dvd_q, dvd_n, dsr_q, orig_q;
  logic [WIDTH-1:0]   abs_a, abs_b, q_res, r_res;
  logic [CNT_W-1:0]   count_q;
  logic               sign_q_q, sign_r_q, dz_q;
  logic               last_iter;

  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (in_valid && !cancel) state_n = BUSY;
      BUSY: begin
        if (cancel)         state_n = IDLE;
        else if (last_iter) state_n = DONE;
      end
      DONE:    if (cancel || out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand magnitudes, one restoring step, and the sign-corrected result
  always_comb begin
    abs_a   = (div_signed && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
    abs_b   = (div_signed && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
    shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_q};
    rem_n   = shifted;
    dvd_n   = {dvd_q[WIDTH-2:0], 1'b0};
    // The partial remainder stays below the divisor, so diff's top bit is its sign
    if (!diff[WIDTH]) begin
      rem_n = diff;
      dvd_n = {dvd_q[WIDTH-2:0], 1'b1};
    end
    q_res = sign_q_q ? WIDTH'(-dvd_n) : dvd_n;
    r_res = sign_r_q ? WIDTH'(-rem_n[WIDTH-1:0]) : rem_n[WIDTH-1:0];
    if (dz_q) begin
      q_res = '1;
      r_res = orig_q;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      orig_q    <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      if (state_q == IDLE && state_n == BUSY) begin
        rem_q    <= '0;
        dvd_q    <= abs_a;
        dsr_q    <= abs_b;
        orig_q   <= dividend;
        sign_q_q <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        sign_r_q <= div_signed & dividend[WIDTH-1];
        dz_q     <= (divisor == '0);
        count_q  <= '0;
      end
      if (state_q == BUSY) begin
        rem_q   <= rem_n;
        dvd_q   <= dvd_n;
        count_q <= count_q + CNT_W'(1);
        if (state_n == DONE) begin
          quotient  <= q_res;
          remainder <= r_res;
        end
      end
    end
  end

endmodule
